// File: rtl/rotary_quad_gen.sv
// Quadrature generator emulating a mechanical rotary encoder: each accepted step
// command becomes one detent (four Gray-code transitions) followed by an idle gap.
module rotary_quad_gen #(
    parameter int DIV_WIDTH = 16,
    parameter int POS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_valid,
    input  logic                 step_dir,
    output logic                 step_ready,
    input  logic [DIV_WIDTH-1:0] period,
    output logic                 clk_out,
    output logic                 dt_out,
    output logic                 busy,
    output logic                 done,
    output logic [POS_WIDTH-1:0] position
);

    // state | meaning
    // IDLE  | nothing in progress, outputs parked at 11
    // RUN   | stepping through the four transitions of a detent
    // GAP   | one phase period held at 11 before the next detent may start
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [1:0]           phase_idx_q, phase_idx_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] period_l_q, period_l_d;
    logic                 dir_l_q, dir_l_d;
    logic                 hold_valid_q, hold_valid_d;
    logic                 hold_dir_q, hold_dir_d;
    logic [1:0]           quad_q, quad_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;

    logic [DIV_WIDTH-1:0] period_eff;
    logic                 accept;

    function automatic logic [1:0] quad_pat(input logic dir, input logic [1:0] idx);
        logic [1:0] pat;
        case (idx)
            2'd0:    pat = dir ? 2'b10 : 2'b01;
            2'd1:    pat = 2'b00;
            2'd2:    pat = dir ? 2'b01 : 2'b10;
            default: pat = 2'b11;
        endcase
        return pat;
    endfunction

    assign period_eff = (period == '0) ? DIV_WIDTH'(1) : period;
    assign step_ready = ~hold_valid_q;
    assign accept     = step_valid & ~hold_valid_q;

    always_comb begin
        state_d      = state_q;
        phase_idx_d  = phase_idx_q;
        div_d        = div_q;
        period_l_d   = period_l_q;
        dir_l_d      = dir_l_q;
        hold_valid_d = hold_valid_q;
        hold_dir_d   = hold_dir_q;
        quad_d       = quad_q;
        done_d       = 1'b0;
        pos_d        = pos_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_RUN;
                    dir_l_d     = step_dir;
                    period_l_d  = period_eff;
                    div_d       = period_eff - DIV_WIDTH'(1);
                    phase_idx_d = 2'd0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    hold_valid_d = 1'b1;
                    hold_dir_d   = step_dir;
                end
                if (div_q == '0) begin
                    quad_d      = quad_pat(dir_l_q, phase_idx_q);
                    phase_idx_d = phase_idx_q + 2'd1;
                    div_d       = period_l_q - DIV_WIDTH'(1);
                    if (phase_idx_q == 2'd3) begin
                        state_d = S_GAP;
                        done_d  = 1'b1;
                        pos_d   = dir_l_q ? pos_q - POS_WIDTH'(1) : pos_q + POS_WIDTH'(1);
                    end
                end else begin
                    div_d = div_q - DIV_WIDTH'(1);
                end
            end
            S_GAP: begin
                if (div_q == '0) begin
                    // a held command takes priority; ready is low then, so no new accept
                    if (hold_valid_q || accept) begin
                        state_d      = S_RUN;
                        dir_l_d      = hold_valid_q ? hold_dir_q : step_dir;
                        period_l_d   = period_eff;
                        div_d        = period_eff - DIV_WIDTH'(1);
                        phase_idx_d  = 2'd0;
                        hold_valid_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q - DIV_WIDTH'(1);
                    if (accept) begin
                        hold_valid_d = 1'b1;
                        hold_dir_d   = step_dir;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                quad_d       = 2'b11;
                hold_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_idx_q  <= 2'd0;
            div_q        <= '0;
            period_l_q   <= DIV_WIDTH'(1);
            dir_l_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_dir_q   <= 1'b0;
            quad_q       <= 2'b11;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            pos_q        <= '0;
        end else begin
            state_q      <= state_d;
            phase_idx_q  <= phase_idx_d;
            div_q        <= div_d;
            period_l_q   <= period_l_d;
            dir_l_q      <= dir_l_d;
            hold_valid_q <= hold_valid_d;
            hold_dir_q   <= hold_dir_d;
            quad_q       <= quad_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            pos_q        <= pos_d;
        end
    end

    assign clk_out  = quad_q[1];
    assign dt_out   = quad_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign position = pos_q;

endmodule

// File: tb/tb_rotary_quad_gen.sv
// Directed bench for rotary_quad_gen: table of single-detent vectors plus
// hand-written sequences for backpressure, same-edge launch, reset and period latch.
module tb_rotary_quad_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_valid = 1'b0;
    logic        step_dir = 1'b0;
    logic        step_ready;
    logic [15:0] period = 16'd1;
    logic        clk_out;
    logic        dt_out;
    logic        busy;
    logic        done;
    logic [7:0]  position;

    int checks = 0;
    int errors = 0;

    rotary_quad_gen #(.DIV_WIDTH(16), .POS_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .step_ready (step_ready),
        .period     (period),
        .clk_out    (clk_out),
        .dt_out     (dt_out),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_reset;
        logic        dir;
        logic [15:0] per;
        int          p_eff;
        logic [7:0]  seq;
        logic [7:0]  exp_pos;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        step_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] exp_out;
        int idx;
        if (v.do_reset) do_reset();
        step_valid = 1'b1;
        step_dir   = v.dir;
        period     = v.per;
        tick();
        step_valid = 1'b0;
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_out", {30'd0, clk_out, dt_out}, 32'd3);
        for (int k = 1; k <= 5 * v.p_eff; k++) begin
            tick();
            idx = k / v.p_eff;
            if (idx == 0 || idx >= 4) exp_out = 2'b11;
            else exp_out = v.seq[7 - 2 * (idx - 1) -: 2];
            chk("vec_out", {30'd0, clk_out, dt_out}, {30'd0, exp_out});
            chk("vec_done", {31'd0, done}, {31'd0, (k == 4 * v.p_eff)});
            chk("vec_busy", {31'd0, busy}, {31'd0, (k < 5 * v.p_eff)});
        end
        chk("vec_pos", {24'd0, position}, {24'd0, v.exp_pos});
    endtask

    logic       acc;
    int         nacc;
    int         acc_edge[3];
    logic       dirs[3];

    initial begin
        vecs[0] = '{do_reset: 1'b1, dir: 1'b0, per: 16'd2, p_eff: 2, seq: 8'b01_00_10_11, exp_pos: 8'd1};
        vecs[1] = '{do_reset: 1'b1, dir: 1'b1, per: 16'd3, p_eff: 3, seq: 8'b10_00_01_11, exp_pos: 8'd255};
        vecs[2] = '{do_reset: 1'b0, dir: 1'b1, per: 16'd0, p_eff: 1, seq: 8'b10_00_01_11, exp_pos: 8'd254};
        vecs[3] = '{do_reset: 1'b0, dir: 1'b0, per: 16'd1, p_eff: 1, seq: 8'b01_00_10_11, exp_pos: 8'd255};
        vecs[4] = '{do_reset: 1'b1, dir: 1'b0, per: 16'd5, p_eff: 5, seq: 8'b01_00_10_11, exp_pos: 8'd1};

        do_reset();
        chk("rst_out", {30'd0, clk_out, dt_out}, 32'd3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, step_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pos", {24'd0, position}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // back-to-back with backpressure, period 1
        do_reset();
        period = 16'd1;
        dirs[0] = 1'b0; dirs[1] = 1'b0; dirs[2] = 1'b1;
        nacc = 0;
        step_valid = 1'b1;
        step_dir   = dirs[0];
        for (int e = 0; e <= 16; e++) begin
            acc = step_valid && step_ready;
            tick();
            if (acc) begin
                acc_edge[nacc] = e;
                nacc++;
                if (nacc < 3) step_dir = dirs[nacc];
                else step_valid = 1'b0;
            end
            chk("b2b_busy", {31'd0, busy}, {31'd0, (e < 15)});
            if (e == 1 || e == 6) chk("b2b_start_cw", {30'd0, clk_out, dt_out}, 32'd1);
            if (e == 11) chk("b2b_start_ccw", {30'd0, clk_out, dt_out}, 32'd2);
            if (e == 5 || e == 10) chk("b2b_gap", {30'd0, clk_out, dt_out}, 32'd3);
            if (e == 1) chk("b2b_ready_low", {31'd0, step_ready}, 32'd0);
            if (e == 5) chk("b2b_ready_back", {31'd0, step_ready}, 32'd1);
            if (e == 14) chk("b2b_pos", {24'd0, position}, 32'd1);
        end
        chk("b2b_nacc", nacc, 32'd3);
        chk("b2b_acc1", acc_edge[1], 32'd1);
        chk("b2b_acc2", acc_edge[2], 32'd6);

        // same-edge accept at gap expiry launches directly
        do_reset();
        period = 16'd1;
        step_valid = 1'b1;
        step_dir = 1'b0;
        tick();
        step_valid = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        step_valid = 1'b1;
        step_dir = 1'b1;
        tick();
        step_valid = 1'b0;
        chk("same_edge_busy", {31'd0, busy}, 32'd1);
        chk("same_edge_ready", {31'd0, step_ready}, 32'd1);
        tick();
        chk("same_edge_first", {30'd0, clk_out, dt_out}, 32'd2);
        for (int e = 7; e <= 10; e++) tick();
        chk("same_edge_pos", {24'd0, position}, 32'd0);

        // reset mid-detent with a held command pending
        do_reset();
        period = 16'd4;
        step_valid = 1'b1;
        step_dir = 1'b0;
        tick();
        tick();
        step_valid = 1'b0;
        chk("mid_ready_held", {31'd0, step_ready}, 32'd0);
        for (int e = 2; e <= 6; e++) tick();
        chk("mid_pre_out", {30'd0, clk_out, dt_out}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {30'd0, clk_out, dt_out}, 32'd3);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, step_ready}, 32'd1);
        chk("mid_rst_pos", {24'd0, position}, 32'd0);
        tick();
        rst = 1'b0;
        for (int e = 0; e < 30; e++) begin
            tick();
            chk("post_rst_out", {30'd0, clk_out, dt_out}, 32'd3);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end

        // period changed mid-detent only affects the next command
        do_reset();
        period = 16'd2;
        step_valid = 1'b1;
        step_dir = 1'b0;
        tick();
        step_valid = 1'b0;
        for (int e = 1; e <= 3; e++) tick();
        period = 16'd7;
        tick();
        chk("latch_e4", {30'd0, clk_out, dt_out}, 32'd0);
        tick();
        chk("latch_e5", {30'd0, clk_out, dt_out}, 32'd0);
        tick();
        chk("latch_e6", {30'd0, clk_out, dt_out}, 32'd2);
        tick();
        tick();
        chk("latch_e8", {30'd0, clk_out, dt_out}, 32'd3);
        chk("latch_done", {31'd0, done}, 32'd1);
        tick();
        tick();
        chk("latch_idle", {31'd0, busy}, 32'd0);
        step_valid = 1'b1;
        step_dir = 1'b1;
        tick();
        step_valid = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        chk("latch_new_e6", {30'd0, clk_out, dt_out}, 32'd3);
        tick();
        chk("latch_new_e7", {30'd0, clk_out, dt_out}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
